// File: rtl/cbfp1_pkg.sv
// Shared defaults, block scale pair type and controller state encoding
// for the CBFP stage-1 scale controller.
package cbfp1_pkg;

    localparam int unsigned CBFP1_LZC_WIDTH = 5;
    localparam int unsigned CBFP1_BLK_CYC   = 8;

    typedef struct packed {
        logic [CBFP1_LZC_WIDTH-1:0] add;
        logic [CBFP1_LZC_WIDTH-1:0] sub;
    } scale_pair_t;

    typedef enum logic [0:0] {
        StIdle,
        StAccum
    } state_e;

endpackage

// File: rtl/cbfp1_scale_ctrl_if.sv
// Block scale handshake between the stage-1 scale controller (master)
// and the scaling/shift unit (slave).
interface cbfp1_scale_ctrl_if
    import cbfp1_pkg::*;
#(
    parameter int unsigned LZC_WIDTH = CBFP1_LZC_WIDTH
);
    logic [LZC_WIDTH-1:0] scale_add;
    logic [LZC_WIDTH-1:0] scale_sub;
    logic                 scale_valid;
    logic                 scale_ready;

    modport master (
        output scale_add,
        output scale_sub,
        output scale_valid,
        input  scale_ready
    );

    modport slave (
        input  scale_add,
        input  scale_sub,
        input  scale_valid,
        output scale_ready
    );
endinterface

// File: rtl/cbfp1_scale_fifo.sv
// Two-entry FIFO of block scale pairs with registered head. A pop is applied
// before a push in the same cycle, so push+pop while full never drops.
module cbfp1_scale_fifo
    import cbfp1_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        push,
    input  scale_pair_t push_data,
    input  logic        pop,
    output scale_pair_t head,
    output logic        full,
    output logic        empty
);
    scale_pair_t head_q, head_d;
    scale_pair_t tail_q, tail_d;
    logic [1:0]  count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop && (count_q != 2'd0)) begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
        end
        if (push) begin
            case (count_d)
                2'd0: begin
                    head_d  = push_data;
                    count_d = 2'd1;
                end
                2'd1: begin
                    tail_d  = push_data;
                    count_d = 2'd2;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head  = head_q;
    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);

endmodule

// File: rtl/cbfp1_scale_ctrl.sv
// CBFP stage-1 scale controller: reduces detector minima over a block and queues
// one scale pair per block. Optional clamp to MAX_SHIFT under `CBFP1_SAT_EN.
module cbfp1_scale_ctrl
    import cbfp1_pkg::*;
#(
    parameter int unsigned LZC_WIDTH = CBFP1_LZC_WIDTH,
    parameter int unsigned BLK_CYC   = CBFP1_BLK_CYC,
    parameter int unsigned PIPE_LAT  = 2,
    parameter int unsigned MAX_SHIFT = 12
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       in_valid,
    input  logic                       flush,
    output logic                       det_en,
    input  logic [LZC_WIDTH-1:0]       det_min_add,
    input  logic [LZC_WIDTH-1:0]       det_min_sub,
    output logic [$clog2(BLK_CYC)-1:0] blk_cnt,
    output logic                       ovf_err,
    cbfp1_scale_ctrl_if.master         scale_if
);
    localparam int unsigned          CntW    = $clog2(BLK_CYC);
    localparam logic [CntW-1:0]      CntLast = CntW'(BLK_CYC - 1);
    localparam logic [LZC_WIDTH-1:0] SatCeil = LZC_WIDTH'(MAX_SHIFT);
`ifdef CBFP1_SAT_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif

    function automatic logic [LZC_WIDTH-1:0] sat_scale(input logic [LZC_WIDTH-1:0] v);
        return (SatEn && (v > SatCeil)) ? SatCeil : v;
    endfunction

    logic [PIPE_LAT-1:0]  vld_sr_q, vld_sr_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [LZC_WIDTH-1:0] acc_add_q, acc_add_d;
    logic [LZC_WIDTH-1:0] acc_sub_q, acc_sub_d;
    logic                 ovf_err_q, ovf_err_d;
    state_e               state_q, state_d;

    logic                 min_vld, take, pend;
    logic [LZC_WIDTH-1:0] min_add, min_sub;
    logic                 blk_push, pop, drop, full, empty;
    scale_pair_t          blk_pair, head;

    always_comb begin
        det_en  = in_valid & ~flush;
        min_vld = vld_sr_q[PIPE_LAT-1];
        take    = min_vld & ~flush;

        // Anything still in flight that will become min_vld on a later cycle.
        pend = 1'b0;
        for (int i = 0; i < int'(PIPE_LAT) - 1; i++) begin
            pend = pend | vld_sr_q[i];
        end

        vld_sr_d = '0;
        if (!flush) begin
            vld_sr_d[0] = det_en;
            for (int i = 1; i < int'(PIPE_LAT); i++) begin
                vld_sr_d[i] = vld_sr_q[i-1];
            end
        end

        min_add      = (det_min_add < acc_add_q) ? det_min_add : acc_add_q;
        min_sub      = (det_min_sub < acc_sub_q) ? det_min_sub : acc_sub_q;
        blk_push     = take && (cnt_q == CntLast);
        blk_pair.add = sat_scale(min_add);
        blk_pair.sub = sat_scale(min_sub);

        cnt_d     = cnt_q;
        acc_add_d = acc_add_q;
        acc_sub_d = acc_sub_q;
        state_d   = state_q;
        if (flush) begin
            cnt_d     = '0;
            acc_add_d = '1;
            acc_sub_d = '1;
            state_d   = StIdle;
        end else if (take) begin
            cnt_d     = cnt_q + CntW'(1);
            acc_add_d = (cnt_q == '0) ? det_min_add : min_add;
            acc_sub_d = (cnt_q == '0) ? det_min_sub : min_sub;
            case (state_q)
                StIdle:  state_d = StAccum;
                StAccum: if (blk_push && !pend) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end

        pop       = ~empty & scale_if.scale_ready;
        drop      = blk_push & full & ~pop;
        ovf_err_d = ovf_err_q | drop;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_sr_q  <= '0;
            cnt_q     <= '0;
            acc_add_q <= '1;
            acc_sub_q <= '1;
            ovf_err_q <= 1'b0;
            state_q   <= StIdle;
        end else begin
            vld_sr_q  <= vld_sr_d;
            cnt_q     <= cnt_d;
            acc_add_q <= acc_add_d;
            acc_sub_q <= acc_sub_d;
            ovf_err_q <= ovf_err_d;
            state_q   <= state_d;
        end
    end

    cbfp1_scale_fifo u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (blk_push),
        .push_data (blk_pair),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    assign scale_if.scale_add   = head.add;
    assign scale_if.scale_sub   = head.sub;
    assign scale_if.scale_valid = ~empty;
    assign blk_cnt              = cnt_q;
    assign ovf_err              = ovf_err_q;

endmodule

// File: doc/cbfp1_scale_ctrl.md
Name: cbfp1_scale_ctrl

Overview:
Sequences the CBFP stage-1 minimum-LZC detector across a full CBFP block. Drives the detector enable and tracks its fixed pipeline latency. Reduces the per-cycle add/sub minima over BLK_CYC valid cycles into one block scale pair and queues it in a 2-entry FIFO. Sits between the butterfly-1 output valid and the stage-1 scaling/shift unit, which pops scale values with a valid/ready handshake.

Parameters:
LZC_WIDTH, 5, bit width of LZC/min values
BLK_CYC, 8, detector-valid cycles per CBFP block (8 lanes x 8 = 64 points); power of two, >=2
PIPE_LAT, 2, detector latency from en to registered minima
MAX_SHIFT, 12, scale ceiling applied when CBFP1_SAT_EN is defined

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
in_valid  in  1  butterfly-1 lane data valid this cycle
flush  in  1  synchronous abort of partial block and pipeline
det_en  out  1  enable to min detector (= in_valid & ~flush)
det_min_add  in  LZC_WIDTH  registered add-path minimum from detector
det_min_sub  in  LZC_WIDTH  registered sub-path minimum from detector
scale_add  out  LZC_WIDTH  FIFO head, add-path block scale
scale_sub  out  LZC_WIDTH  FIFO head, sub-path block scale
scale_valid  out  1  FIFO non-empty
scale_ready  in  1  consumer accepts head
blk_cnt  out  $clog2(BLK_CYC)  current in-block cycle index
ovf_err  out  1  sticky: a completed block was dropped because FIFO full

Behaviour:
- Reset is asynchronous, active-low, on clk. Reset values: valid shift reg 0, cnt 0, accumulators all-ones, FIFO empty, scale_valid 0, scale_add/scale_sub 0, ovf_err 0, state IDLE.
- det_en is combinational: in_valid & ~flush.
- Latency tracking: a PIPE_LAT-deep shift register of det_en produces min_vld, aligned with det_min_*.
- FSM states:
  - IDLE: cnt=0. min_vld moves to ACCUM.
  - ACCUM: accumulating.
  - ACCUM returns to IDLE when the last cycle is pushed and no min_vld is pending in the shift register.
- Accumulation on min_vld:
  - cnt==0: acc_x <= det_min_x.
  - Otherwise: acc_x <= min(acc_x, det_min_x), unsigned compare.
  - cnt increments mod BLK_CYC.
- Block completion: when min_vld && cnt==BLK_CYC-1, push {min(acc_add,det_min_add), min(acc_sub,det_min_sub)}. cnt wraps to 0, so back-to-back blocks have no bubble.
- FIFO: 2 entries, registered outputs. scale_* show the head; scale_valid = ~empty.
  - Pop on scale_valid & scale_ready.
  - Simultaneous push and pop when full: legal. Pop is applied first, so no overflow.
  - Push when full without pop: block dropped, ovf_err <= 1 (sticky until reset), FIFO unchanged.
  - Push into empty FIFO: scale_valid rises on the next cycle, so completion-to-valid latency is 1 cycle.
- flush:
  - Clears the valid shift reg, cnt and accumulators, and sets state IDLE.
  - FIFO contents are retained.
  - A min_vld coinciding with flush is discarded.
- Gaps in in_valid stall accumulation; cnt holds.
- Holding scale_ready low has no effect on accumulation.
- Reset mid-block discards all partial state immediately.

Optional Feature:
CBFP1_SAT_EN:
- Defined: pushed scales are clamped to MAX_SHIFT, i.e. value = min(block_min, MAX_SHIFT).
- Undefined: raw block minimum is pushed. MAX_SHIFT is unused.

Decomposition:
- Package cbfp1_pkg: LZC_WIDTH default, BLK_CYC default, typedef scale_pair_t {logic [LZC_WIDTH-1:0] add, sub;}, state enum {IDLE, ACCUM}.
- One sub-module: cbfp1_scale_fifo (2-entry FIFO of scale_pair_t with push/pop/full/empty).
- Accumulator, counter and FSM stay in the top module.

Test Plan:
- Block reduction: 8 consecutive in_valid, det_min_add 9,7,11,6,8,10,12,9 and det_min_sub all 4, scale_ready=1 -> after PIPE_LAT+8 cycles a single push; scale_valid pulses 1 cycle with scale_add=6, scale_sub=4.
- Back-to-back blocks: 16 continuous valids, block A minimum 3/5, block B minimum 7/2 -> two FIFO entries in order (3,5) then (7,2). blk_cnt wraps 7->0 with no idle cycle.
- FIFO full: scale_ready=0 across 3 blocks -> first two held, third dropped, ovf_err=1. Then scale_ready=1 pops the first two correctly, and ovf_err stays 1.
- Flush mid-block: 5 valids, flush pulse, then 8 fresh valids with min 10 -> one entry of 10. The earlier partial minimum (e.g. 2) never appears.
- Stall and simultaneous push/pop: in_valid gaps of 3 cycles inside a block give the same result as contiguous input. With FIFO full, a push coinciding with a pop -> no ovf_err.
- CBFP1_SAT_EN defined, MAX_SHIFT=12: block minimum 17 -> scale 12. Undefined: scale 17.
